// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiters: FSM state encoding,
// the double-width round-robin picker and a one-hot to binary encoder.
package wrr_arb_pkg;

    localparam int MAX_N   = 32;
    localparam int MAX_IDW = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set req bit at or above the one-hot pointer, wrapping to bit 0.
    // Zero padding above the real width is harmless: the borrow simply runs
    // through it into the upper copy when nothing is found at/above pointer.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0] req,
        input logic [MAX_N-1:0] pointer
    );
        logic [2*MAX_N-1:0] dbl;
        logic [2*MAX_N-1:0] gnt_dbl;
        dbl     = {req, req};
        gnt_dbl = dbl & ~(dbl - {{MAX_N{1'b0}}, pointer});
        return gnt_dbl[MAX_N-1:0] | gnt_dbl[2*MAX_N-1:MAX_N];
    endfunction

    function automatic logic [MAX_IDW-1:0] onehot2bin(input logic [MAX_N-1:0] onehot);
        logic [MAX_IDW-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (onehot[i]) bin = bin | MAX_IDW'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Parametrised combinational round-robin picker; returns a one-hot winner
// (or zero when no request is present).
module rr_pick_comb
    import wrr_arb_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_pointer,
    output logic [N-1:0] o_grant
);

    assign o_grant = N'(rr_pick(MAX_N'(i_req), MAX_N'(i_pointer)));

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with packet locking: a winner keeps the grant
// for up to weight[i] packets, or until it idles between packets.
module wrr_burst_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N   = 5,
    parameter int W   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   weight,
    input  logic             ack,
    input  logic             last,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_nxt;
    logic [N-1:0]   r_ptr;
    logic [N-1:0]   w_ptr_nxt;
    logic [W-1:0]   r_credit;
    logic [W-1:0]   w_credit_nxt;
    logic           r_in_pkt;
    logic           w_in_pkt_nxt;

    logic [N-1:0]   w_pick;
    logic [W-1:0]   w_win_weight;
    logic [W-1:0]   w_win_credit;
    logic           w_req_g;
    logic           w_release;

    rr_pick_comb #(.N(N)) u_pick (
        .i_req     (req),
        .i_pointer (r_ptr),
        .o_grant   (w_pick)
    );

    always_comb begin
        w_win_weight = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i]) w_win_weight = w_win_weight | weight[i*W +: W];
        end
    end

    assign w_win_credit = (w_win_weight == '0) ? W'(1) : w_win_weight;

    // Idle release only applies between packets; mid-packet the lock holds.
    assign w_req_g   = |(req & r_grant);
    assign w_release = (ack & last & (r_credit == W'(1)))
                     | (~r_in_pkt & ~ack & ~w_req_g);

    // NOTE: every next-state signal is given its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        w_in_pkt_nxt = r_in_pkt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant_nxt  = w_pick;
                    w_credit_nxt = w_win_credit;
                    w_in_pkt_nxt = 1'b0;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    if (last) begin
                        w_in_pkt_nxt = 1'b0;
                        w_credit_nxt = r_credit - W'(1);
                    end else begin
                        w_in_pkt_nxt = 1'b1;
                    end
                end
                if (w_release) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = {r_grant[N-2:0], r_grant[N-1]};
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_ptr    <= N'(1);
            r_credit <= '0;
            r_in_pkt <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
            r_in_pkt <= w_in_pkt_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = IDW'(onehot2bin(MAX_N'(r_grant)));

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter (N=4, W=4) with an integer-level
// reference model compared every cycle plus literal grant expectations.
module tb_wrr_burst_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] weight = '0;
    logic           ack = 1'b0;
    logic           last = 1'b0;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Reference model state: granted index (-1 = none), pointer index, quota.
    int m_gnt    = -1;
    int m_ptr    = 0;
    int m_credit = 0;
    bit m_in_pkt = 1'b0;
    bit m_rel;
    int m_wt;

    wrr_burst_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .ack         (ack),
        .last        (last),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_gnt    = -1;
            m_ptr    = 0;
            m_credit = 0;
            m_in_pkt = 1'b0;
        end else if (m_gnt < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_gnt < 0 && req[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
            end
            if (m_gnt >= 0) begin
                m_wt     = int'(weight[m_gnt*W +: W]);
                m_credit = (m_wt == 0) ? 1 : m_wt;
                m_in_pkt = 1'b0;
            end
        end else begin
            m_rel = (ack && last && m_credit == 1) || (!m_in_pkt && !ack && !req[m_gnt]);
            if (ack && !last) m_in_pkt = 1'b1;
            if (ack && last) begin
                m_in_pkt = 1'b0;
                m_credit = m_credit - 1;
            end
            if (m_rel) begin
                m_ptr = (m_gnt + 1) % N;
                m_gnt = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N-1:0] exp_g;
            exp_g = (m_gnt < 0) ? '0 : N'(1 << m_gnt);
            check("model_grant", 32'(grant), 32'(exp_g));
            check("model_valid", 32'(grant_valid), (m_gnt >= 0) ? 32'd1 : 32'd0);
            check("model_id", 32'(grant_id), (m_gnt < 0) ? 32'd0 : 32'(m_gnt));
        end
    end

    task automatic tick(input string name, input logic [N-1:0] exp);
        @(posedge clk);
        #1;
        check(name, 32'(grant), 32'(exp));
    endtask

    logic [N-1:0] t1_exp [8]  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                  4'b0100, 4'b0000, 4'b1000, 4'b0000};
    logic [N-1:0] t2_exp [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                  4'b0001};

    initial begin
        bit beat;

        // Reset, then idle with no requests.
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick("idle_grant", 4'b0000);
            check("idle_valid", 32'(grant_valid), 32'd0);
            check("idle_id", 32'(grant_id), 32'd0);
        end

        // Equal weights, single-beat packets: plain rotation with bubbles.
        weight = 16'h1111;
        req    = 4'b1111;
        ack    = 1'b1;
        last   = 1'b1;
        for (int i = 0; i < 8; i++) tick("rotate", t1_exp[i]);
        req  = 4'b0000;
        ack  = 1'b0;
        last = 1'b0;
        tick("rotate_end", 4'b0000);

        // Requester 0 weight 3 with two-beat packets.
        weight = 16'h1113;
        req    = 4'b0011;
        beat   = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (!grant_valid) begin
                ack  = 1'b0;
                last = 1'b0;
                beat = 1'b0;
            end else begin
                ack  = 1'b1;
                last = beat;
                beat = ~beat;
            end
            tick("weighted", t2_exp[i]);
        end
        req  = 4'b0000;
        ack  = 1'b0;
        last = 1'b0;
        tick("weighted_idle_rel", 4'b0000);

        // Requester 2 sends one packet then idles: early release, pointer to 3.
        weight = 16'h1411;
        req    = 4'b0100;
        tick("idle_rel_grant", 4'b0100);
        ack = 1'b1; last = 1'b0;
        tick("idle_rel_beat0", 4'b0100);
        ack = 1'b1; last = 1'b1;
        tick("idle_rel_beat1", 4'b0100);
        req = 4'b0001; ack = 1'b0; last = 1'b0;
        tick("idle_rel_drop", 4'b0000);
        req = 4'b0101;
        tick("idle_rel_wrap", 4'b0001);
        req = 4'b0000;
        tick("idle_rel_end", 4'b0000);

        // Requester 1 drops req mid-packet: lock holds until the last beat.
        weight = 16'h1111;
        req    = 4'b0010;
        tick("lock_grant", 4'b0010);
        ack = 1'b1; last = 1'b0;
        tick("lock_first", 4'b0010);
        req = 4'b0000; ack = 1'b0;
        for (int i = 0; i < 3; i++) tick("lock_hold", 4'b0010);
        ack = 1'b1; last = 1'b1;
        tick("lock_release", 4'b0000);
        ack = 1'b0; last = 1'b0;

        // Reset mid-packet clears the lock and the pointer.
        req = 4'b0100;
        tick("rst_grant", 4'b0100);
        ack = 1'b1; last = 1'b0;
        tick("rst_in_pkt", 4'b0100);
        rst = 1'b1; ack = 1'b0; req = 4'b0000;
        tick("rst_clear", 4'b0000);
        rst = 1'b0; req = 4'b1010;
        tick("rst_ptr0", 4'b0010);
        check("rst_ptr0_id", 32'(grant_id), 32'd1);
        req = 4'b0000;
        tick("rst_end", 4'b0000);

        // Ack while idle is ignored; weight 0 behaves as a quota of 1.
        weight = 16'h0111;
        ack = 1'b1; last = 1'b1;
        tick("idle_ack_a", 4'b0000);
        tick("idle_ack_b", 4'b0000);
        req = 4'b1000;
        tick("w0_grant", 4'b1000);
        check("w0_id", 32'(grant_id), 32'd3);
        tick("w0_release", 4'b0000);
        req = 4'b0000; ack = 1'b0; last = 1'b0;
        tick("final_idle", 4'b0000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Parametrised weighted round-robin arbiter with packet locking. It sits in front of a shared resource (bus or FIFO write port) fed by N requesters.
- A winner keeps the grant for up to WEIGHT[i] complete packets, or until it goes idle between packets, before the rotating pointer advances.
- Packet boundaries are taken from a downstream ack/last handshake.
- Grant is registered; a packet is never split between requesters.

Parameters:
- N, 5: number of requesters (N >= 2).
- W, 4: width of each per-requester weight field.
- IDW, $clog2(N): width of grant_id.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request vector, one bit per requester.
- weight  in  N*W  packed per-requester packet quota; field i is weight[i*W +: W]. A value of 0 is treated as 1.
- ack  in  1  downstream accepts one beat from the granted requester this cycle.
- last  in  1  the beat accepted this cycle is the final beat of a packet (qualified by ack).
- grant  out  N  one-hot grant, registered.
- grant_valid  out  1  OR of grant.
- grant_id  out  IDW  binary index of the granted requester (0 when grant_valid=0).

Behaviour:
- Reset:
  - grant=0, grant_valid=0, grant_id=0.
  - pointer=one-hot bit 0, credit=0, in_pkt=0, state=IDLE.
  - Reset asserted mid-packet aborts the lock immediately; no partial state survives.
- State IDLE:
  - If req != 0, the winner is the first set req bit at or above pointer, wrapping via the double-width subtract/mask method.
  - Next edge: grant <= winner, credit <= max(weight[winner],1), in_pkt <= 0, state <= GRANT.
  - Latency req -> grant is 1 clock.
  - If req == 0, stay in IDLE with grant=0.
- State GRANT, granted index g. Each cycle:
  - ack & ~last: in_pkt <= 1.
  - ack & last: in_pkt <= 0, credit <= credit-1.
  - Release condition: (ack & last & credit==1) OR (~in_pkt & ~ack & ~req[g]).
  - On release, next edge: grant <= 0, pointer <= pointer one-hot rotated to g+1 (wraps N-1 -> 0), state <= IDLE.
  - Without release, grant is held unchanged.
  - Mid-packet (in_pkt=1), grant is held even if req[g] drops; the requester must not drop req mid-packet, and the arbiter does not check this.
  - A single-beat packet (ack & last with in_pkt=0) counts as one packet.
- Rearbitration bubble: exactly one cycle with grant=0 between successive grants.
- ack while grant_valid=0 is ignored; it does not change credit or in_pkt.
- Weights are sampled only when a grant is issued; weight changes during GRANT take effect on the next grant.
- Invariants:
  - grant is zero or one-hot at all times.
  - grant_id and grant_valid always match grant.
  - No requester with req continuously high waits more than (N-1) full tenures.

Decomposition:
- Package wrr_arb_pkg:
  - state enum typedef (IDLE, GRANT).
  - function rr_pick(req, pointer) returning the one-hot winner.
  - function onehot2bin.
- One sub-module is natural: rr_pick_comb, the parametrised combinational round-robin picker (double-width subtract/mask). It is reusable by other arbiters in the codebase.
- The FSM, credit counter and pointer register remain in wrr_burst_arbiter.

Test Plan (N=4, W=4 unless noted):
- Reset then req=4'b0000 for 10 cycles -> grant=0, grant_valid=0, grant_id=0 throughout.
- All weights=1, req=4'b1111 held; every packet is 1 beat (ack=last=1 each granted cycle) -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001...
- weight[0]=3, others 1; req=4'b0011; two-beat packets -> requester 0 granted for 3 packets (6 acked beats), then bubble, then requester 1 for 1 packet, then back to 0.
- Requester 2 granted with credit 4, sends 1 packet, then drops req with in_pkt=0 -> grant released next edge; pointer becomes 4'b1000; with req=4'b0101 the next winner is 0.
- Requester 1 mid-packet (ack&~last seen) drops req for 3 cycles, then ack&last -> grant stays 0010 until after the last beat, then releases.
- Assert rst during GRANT with in_pkt=1 -> next edge grant=0 and pointer=0001; after reset, req=4'b1010 grants requester 1 first.
